buzzer_sequencer: RTL and testbench
===================================

// Module: buzzer_sequencer
// PURPOSE
//   Plays a queue of notes on the buzzer tone generator by sequencing its 32-bit half-period input.
//   - Software pushes {halflen, duration_ms} entries into an internal FIFO.
//   - On start, each note is driven for its duration, followed by a fixed silent gap.
//   - Sits between the CPU peripheral bus registers and the buzzer tone generator.
// PARAMETERS
//   CLK_HZ  50_000_000  clock frequency; ms tick period TICK_DIV = CLK_HZ/1000 cycles (integer, >=2)
//   DEPTH   16          FIFO entries; power of 2, 2..256
//   GAP_MS  10          silent gap after every note, in ms; 0 = no gap
// PORTS
//   clk          in   1             system clock
//   rst          in   1             reset; synchronous, active-high
//   wr_en        in   1             push {wr_halflen, wr_dur} this cycle
//   wr_halflen   in   32            half-period in clk cycles; 0 = rest (silence)
//   wr_dur       in   16            note duration in ms; 0 is treated as 1
//   start        in   1             begin playback (level sampled each cycle; only acts in IDLE)
//   stop         in   1             abort playback and flush FIFO
//   halflen_out  out  32            to tone generator halflen input
//   busy         out  1             1 in NOTE or GAP
//   full         out  1             count == DEPTH
//   count        out  clog2(DEPTH)+1  FIFO occupancy
//   note_done    out  1             1-cycle pulse on leaving NOTE (normal expiry only)
// BEHAVIOUR
//   Reset: all outputs 0, FIFO empty, state IDLE, prescaler and duration counters 0.
//   FIFO:
//   - Push accepted iff wr_en && !full (full taken from the current registered count).
//   - A push while full is silently dropped.
//   - Push and pop in the same cycle leave count unchanged.
//   - Pointers wrap modulo DEPTH.
//   Prescaler: cleared on every state entry; a tick fires when it reaches TICK_DIV-1, then it wraps to 0.
//   IDLE: halflen_out=0, busy=0.
//   - start && count!=0: pop the head entry and go to NOTE.
//   - The next cycle shows halflen_out=head.halflen and busy=1.
//   - start with an empty FIFO: no effect.
//   NOTE: halflen_out holds the note value for exactly max(dur,1)*TICK_DIV cycles.
//   - On the final tick: halflen_out<=0, note_done pulses, and the state goes to GAP (or directly to the next-note/IDLE decision if GAP_MS==0).
//   GAP: halflen_out=0 for exactly GAP_MS*TICK_DIV cycles.
//   - If count!=0: pop and go to NOTE with the new value.
//   - Otherwise: go to IDLE, busy<=0.
//   - Entries pushed during playback are played in order, without restarting.
//   stop: highest priority in every state, after rst.
//   - Next cycle: IDLE, halflen_out=0, busy=0, FIFO empty, no note_done pulse.
//   - A wr_en in the same cycle as stop is dropped.
//   Rest entries (halflen=0) time normally with the output at 0.
//   Every note is preceded by 0 (the gap or IDLE), so the tone generator restarts its phase even for repeated pitches.
//   Duration counter is 16 bits; no other arithmetic. start is ignored while busy.
// TESTING (CLK_HZ=4000 -> TICK_DIV=4, DEPTH=4, GAP_MS=1)
//   1. Push {100,2},{200,3}, start -> halflen_out=100 for 8 cyc, 0 for 4, 200 for 12, 0; note_done x2; busy low after the last gap.
//   2. Push 5 entries with no start -> count=4, full=1; 5th dropped; playback emits only the first 4 values.
//   3. Push {50,0} -> 50 held for exactly 4 cycles (dur 0 treated as 1).
//   4. Mid-note stop while playing {100,5} -> next cycle halflen_out=0, busy=0, count=0, no note_done; a later start has no effect.
//   5. Push {300,1} during the GAP of the last note -> plays 300 after the gap, without returning to IDLE.
//   6. rst asserted mid-NOTE with 3 entries queued -> all outputs 0 and count=0 the next cycle; start is ignored until a new push.

Source files
------------

// File: rtl/buzzer_sequencer.sv
// Note sequencer: plays queued {halflen, duration_ms} entries on the buzzer
// tone generator, with a fixed silent gap after every note.
module buzzer_sequencer #(
  parameter int CLK_HZ = 50_000_000,
  parameter int DEPTH  = 16,
  parameter int GAP_MS = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [31:0]              wr_halflen,
  input  logic [15:0]              wr_dur,
  input  logic                     start,
  input  logic                     stop,
  output logic [31:0]              halflen_out,
  output logic                     busy,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     note_done
);
  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PW       = $clog2(TICK_DIV);
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [15:0]   GAP_LOAD  = (GAP_MS > 0) ? 16'(GAP_MS - 1) : 16'd0;

  typedef struct packed {
    logic [31:0] halflen;
    logic [15:0] dur;
  } note_t;

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  note_t          mem [DEPTH];
  note_t          head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  state_t         state_q, state_d;
  logic [PW-1:0]  presc;
  logic [15:0]    dur_cnt;
  logic           tick, last, push, pop, fin;
  logic [31:0]    halflen_d;
  logic           busy_d;

  assign head = mem[rd_ptr];
  assign full = (count == CW'(DEPTH));
  assign push = wr_en && !full && !stop;
  assign tick = (presc == TICK_LAST);
  assign last = tick && (dur_cnt == 16'd0);

  // FIFO storage and occupancy
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{halflen: wr_halflen, dur: wr_dur};
  end

  always_ff @(posedge clk) begin
    if (rst || stop) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // State register plus timing counters
  always_ff @(posedge clk) begin
    if (rst || stop) begin
      state_q     <= IDLE;
      presc       <= '0;
      dur_cnt     <= '0;
      halflen_out <= '0;
      busy        <= 1'b0;
      note_done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      halflen_out <= halflen_d;
      busy        <= busy_d;
      note_done   <= fin;
      if (state_d != state_q || pop) presc <= '0;
      else if (tick)                 presc <= '0;
      else                           presc <= presc + PRE_ONE;
      if (pop)
        dur_cnt <= (head.dur == 16'd0) ? 16'd0 : head.dur - 16'd1;
      else if (state_q == NOTE && state_d == GAP)
        dur_cnt <= GAP_LOAD;
      else if (tick && dur_cnt != 16'd0)
        dur_cnt <= dur_cnt - 16'd1;
    end
  end

  // Next state; with GAP_MS==0 the gap shrinks to one silent decision cycle
  // so the tone generator still sees 0 between notes.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: if (start && count != '0) begin
        pop     = 1'b1;
        state_d = NOTE;
      end
      NOTE: if (last) begin
        fin     = 1'b1;
        state_d = GAP;
      end
      GAP: if (GAP_MS == 0 || last) begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = NOTE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    halflen_d = 32'd0;
    busy_d    = (state_d != IDLE);
    if (state_d == NOTE) halflen_d = pop ? head.halflen : halflen_out;
  end
endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench for buzzer_sequencer: per-cycle expected waveform scoreboard,
// driven from a note table plus hand-written stop/reset/late-push cases.
module tb_buzzer_sequencer;
  localparam int GAP_CYC = 4;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, stop;
  logic [31:0] wr_halflen, halflen_out;
  logic [15:0] wr_dur;
  logic        busy, full, note_done;
  logic [2:0]  count;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] h;
    logic        b;
    logic        nd;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] h;
    logic [15:0] d;
    int          cyc;
  } vec_t;
  vec_t tbl[6];

  buzzer_sequencer #(.CLK_HZ(4000), .DEPTH(4), .GAP_MS(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_halflen(wr_halflen), .wr_dur(wr_dur),
    .start(start), .stop(stop), .halflen_out(halflen_out), .busy(busy),
    .full(full), .count(count), .note_done(note_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [15:0] d);
    wr_halflen = h; wr_dur = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Expected trace: note value for cyc cycles, then the silent gap whose
  // first cycle carries the note_done pulse.
  task automatic add_note(input logic [31:0] h, input int cyc);
    for (int i = 0; i < cyc; i++) exp_q.push_back('{h: h, b: 1'b1, nd: 1'b0});
    for (int i = 0; i < GAP_CYC; i++) exp_q.push_back('{h: 32'd0, b: 1'b1, nd: (i == 0)});
  endtask

  task automatic run_trace(input string nm, input int inj_at,
                           input logic [31:0] ih, input logic [15:0] id);
    exp_t e;
    int   i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({nm, ".halflen"}, halflen_out, e.h);
      chk({nm, ".busy"}, {31'd0, busy}, {31'd0, e.b});
      chk({nm, ".note_done"}, {31'd0, note_done}, {31'd0, e.nd});
      if (i == inj_at) begin
        wr_halflen = ih; wr_dur = id; wr_en = 1'b1;
      end
      step();
      wr_en = 1'b0;
      i++;
    end
    chk({nm, ".end_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, ".end_halflen"}, halflen_out, 32'd0);
    chk({nm, ".end_count"}, {29'd0, count}, 32'd0);
  endtask

  initial begin
    logic nd_seen;
    tbl[0] = '{h: 32'd100, d: 16'd2, cyc: 8};
    tbl[1] = '{h: 32'd200, d: 16'd3, cyc: 12};
    tbl[2] = '{h: 32'd50,  d: 16'd0, cyc: 4};
    tbl[3] = '{h: 32'd0,   d: 16'd1, cyc: 4};
    tbl[4] = '{h: 32'd77,  d: 16'd4, cyc: 16};
    tbl[5] = '{h: 32'hFFFF_FFFF, d: 16'd1, cyc: 4};

    rst = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0;
    wr_halflen = '0; wr_dur = '0;
    step(); step();
    rst = 1'b0;
    chk("reset.halflen", halflen_out, 32'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.count", {29'd0, count}, 32'd0);
    chk("reset.full", {31'd0, full}, 32'd0);
    chk("reset.note_done", {31'd0, note_done}, 32'd0);

    // Two-note sequence
    push(tbl[0].h, tbl[0].d);
    push(tbl[1].h, tbl[1].d);
    chk("seq.count", {29'd0, count}, 32'd2);
    do_start();
    add_note(tbl[0].h, tbl[0].cyc);
    add_note(tbl[1].h, tbl[1].cyc);
    run_trace("seq", -1, 0, 0);

    // Single-note table entries: dur 0, rest, long note, max value
    for (int i = 2; i < 6; i++) begin
      push(tbl[i].h, tbl[i].d);
      do_start();
      add_note(tbl[i].h, tbl[i].cyc);
      run_trace($sformatf("tbl%0d", i), -1, 0, 0);
    end

    // Overfill: fifth push dropped
    for (int i = 1; i <= 5; i++) push(32'(i * 10), 16'd1);
    chk("fill.count", {29'd0, count}, 32'd4);
    chk("fill.full", {31'd0, full}, 32'd1);
    do_start();
    for (int i = 1; i <= 4; i++) add_note(32'(i * 10), 4);
    run_trace("fill", -1, 0, 0);

    // Mid-note stop
    push(32'd100, 16'd5);
    push(32'd101, 16'd1);
    do_start();
    repeat (6) step();
    chk("stop.pre_halflen", halflen_out, 32'd100);
    stop = 1'b1; wr_halflen = 32'd9; wr_dur = 16'd1; wr_en = 1'b1;
    step();
    stop = 1'b0; wr_en = 1'b0;
    chk("stop.halflen", halflen_out, 32'd0);
    chk("stop.busy", {31'd0, busy}, 32'd0);
    chk("stop.count", {29'd0, count}, 32'd0);
    chk("stop.note_done", {31'd0, note_done}, 32'd0);
    nd_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      nd_seen |= note_done;
      step();
    end
    chk("stop.no_pulse", {31'd0, nd_seen}, 32'd0);
    do_start();
    chk("stop.start_ignored", {31'd0, busy}, 32'd0);
    chk("stop.start_halflen", halflen_out, 32'd0);

    // Push during the gap: next note follows without an IDLE visit
    push(32'd111, 16'd1);
    do_start();
    add_note(32'd111, 4);
    add_note(32'd300, 4);
    run_trace("late", 5, 32'd300, 16'd1);

    // Reset mid-note with entries still queued
    for (int i = 1; i <= 4; i++) push(32'(i * 100), 16'd2);
    do_start();
    chk("rst.pre_count", {29'd0, count}, 32'd3);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst.halflen", halflen_out, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.count", {29'd0, count}, 32'd0);
    chk("rst.full", {31'd0, full}, 32'd0);
    chk("rst.note_done", {31'd0, note_done}, 32'd0);
    do_start();
    chk("rst.start_ignored", {31'd0, busy}, 32'd0);
    push(32'd60, 16'd1);
    do_start();
    add_note(32'd60, 4);
    run_trace("rst_after", -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
